// File: rtl/uart_prog_loader_if.sv
//------------------------------------------------------------------------------
// uart_prog_loader_if : serial-in / ICCM-write-out bundle of the UART loader.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              en_i;
  logic              rx_i;
  logic              ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [ADDR_W:0]   word_count_o;
  logic              done_o;
  logic              frame_err_o;

  modport slave (
    input  en_i, rx_i,
    output ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output word_count_o, done_o, frame_err_o
  );

  modport master (
    output en_i, rx_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  word_count_o, done_o, frame_err_o
  );
endinterface

`default_nettype wire

// File: rtl/uart_prog_loader.sv
//------------------------------------------------------------------------------
// uart_prog_loader : 8N1 UART receiver packing 4 bytes LE into ICCM words.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_WORDS    = 65,
  parameter int ADDR_W       = 14
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  uart_prog_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  c_HALF_M1    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  c_FULL_M1    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   c_NUM_WORDS  = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [ADDR_W:0]   c_ONE        = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_rx_meta;
  logic                r_rx_s;
  logic [CNT_W-1:0]    r_clk_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic [23:0]         r_acc;
  logic [1:0]          r_byte_idx;
  logic [ADDR_W:0]     r_word_count;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_done;
  logic                r_ferr;
  logic                r_ready;

  logic                w_abort;
  logic [ADDR_W:0]     w_count_next;

  assign w_abort      = ~bus.en_i | r_done;
  assign w_count_next = r_word_count + c_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= S_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_acc        <= '0;
      r_byte_idx   <= '0;
      r_word_count <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_done       <= 1'b0;
      r_ferr       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_rx_meta <= bus.rx_i;
      r_rx_s    <= r_rx_meta;
      r_ready   <= bus.en_i & ~r_done;
      r_mem_we  <= 1'b0;

      // Count advances on the cycle that ends the write strobe.
      if (r_mem_we) begin
        r_word_count <= w_count_next;
        if (w_count_next == c_NUM_WORDS) begin
          r_done <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          if (bus.en_i && !r_done && !r_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_clk_cnt == c_HALF_M1) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_clk_cnt == c_FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_clk_cnt == c_FULL_M1) begin
            r_clk_cnt <= '0;
            r_state   <= S_IDLE;
            if (r_rx_s) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              case (r_byte_idx)
                2'd0: r_acc[7:0]   <= r_shift;
                2'd1: r_acc[15:8]  <= r_shift;
                2'd2: r_acc[23:16] <= r_shift;
                default: begin
                  r_mem_we    <= 1'b1;
                  r_mem_wdata <= {r_shift, r_acc};
                  r_mem_addr  <= r_word_count[ADDR_W-1:0];
                end
              endcase
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o      = r_ready;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wdata_o  = r_mem_wdata;
  assign bus.word_count_o = r_word_count;
  assign bus.done_o       = r_done;
  assign bus.frame_err_o  = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
//------------------------------------------------------------------------------
// tb_uart_prog_loader : directed UART loader bench with a write scoreboard.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_prog_loader;

  localparam int CLKS_PER_BIT = 16;
  localparam int NUM_WORDS    = 65;
  localparam int ADDR_W       = 14;
  localparam int CLK_NS       = 100;
  // Sender runs slightly fast against the receiver's 1600 ns bit.
  localparam int BIT_NS       = 1590;
  localparam int STRETCH_NS   = 240;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   post     = 0;
  wr_t  sb[$];
  wr_t  exp_wr;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .NUM_WORDS    (NUM_WORDS),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stretch_ns);
    bus.rx_i = 1'b0;
    #(BIT_NS + stretch_ns);
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = b[i];
      #(BIT_NS);
    end
    bus.rx_i = stop_bit;
    #(BIT_NS);
    bus.rx_i = 1'b1;
  endtask

  task automatic push_wr(input int addr, input logic [31:0] data);
    wr_t w;
    w.addr = ADDR_W'(addr);
    w.data = data;
    sb.push_back(w);
  endtask

  task automatic send_word(input logic [31:0] w, input int stretch_ns);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], 1'b1, stretch_ns);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we_o) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected no write",
               bus.mem_addr_o, bus.mem_wdata_o);
      end
      if (sb.size() > 0) begin
        exp_wr = sb.pop_front();
        check("wr_addr", 64'(bus.mem_addr_o), 64'(exp_wr.addr));
        check("wr_data", 64'(bus.mem_wdata_o), 64'(exp_wr.data));
        if (exp_wr.addr == ADDR_W'(NUM_WORDS - 1)) begin
          check("done_before_last_inc", 64'(bus.done_o), 64'd0);
          post = 1;
        end
      end
    end else if (post == 1) begin
      check("done_after_last", 64'(bus.done_o), 64'd1);
      check("ready_lag_after_last", 64'(bus.ready_o), 64'd1);
      check("count_after_last", 64'(bus.word_count_o), 64'(NUM_WORDS));
      post = 2;
    end else if (post == 2) begin
      check("ready_drop_after_last", 64'(bus.ready_o), 64'd0);
      post = 0;
    end
  end

  initial begin
    bus.en_i = 1'b0;
    bus.rx_i = 1'b1;
    rst_n    = 1'b0;
    #(CLK_NS * 3 + 17);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_we", 64'(bus.mem_we_o), 64'd0);
    check("rst_count", 64'(bus.word_count_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_ferr", 64'(bus.frame_err_o), 64'd0);

    rst_n    = 1'b1;
    bus.en_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("ready_after_rst", 64'(bus.ready_o), 64'd1);

    // Single word with stretched start bits.
    push_wr(0, 32'h0010_0513);
    send_byte(8'h13, 1'b1, STRETCH_NS);
    send_byte(8'h05, 1'b1, STRETCH_NS);
    send_byte(8'h10, 1'b1, STRETCH_NS);
    send_byte(8'h00, 1'b1, STRETCH_NS);
    #(BIT_NS * 2);
    check("single_count", 64'(bus.word_count_o), 64'd1);
    check("single_ferr", 64'(bus.frame_err_o), 64'd0);

    // Short glitch rejected without error.
    bus.rx_i = 1'b0;
    #(CLK_NS * 5);
    bus.rx_i = 1'b1;
    #(BIT_NS * 12);
    check("glitch_count", 64'(bus.word_count_o), 64'd1);
    check("glitch_ferr", 64'(bus.frame_err_o), 64'd0);

    push_wr(1, 32'hCAFE_F00D);
    send_word(32'hCAFE_F00D, 0);
    #(BIT_NS * 2);
    check("word1_count", 64'(bus.word_count_o), 64'd2);

    // Enable abort during byte 1 of word 2.
    push_wr(2, 32'hD4C3_B2A1);
    send_byte(8'hA1, 1'b1, 0);
    bus.rx_i = 1'b0;
    #(BIT_NS * 3 + BIT_NS / 2);
    bus.en_i = 1'b0;
    bus.rx_i = 1'b1;
    #(BIT_NS * 2);
    bus.en_i = 1'b1;
    #(BIT_NS * 2);
    send_byte(8'hB2, 1'b1, 0);
    send_byte(8'hC3, 1'b1, 0);
    #(BIT_NS);
    check("abort_no_early_write", 64'(bus.word_count_o), 64'd2);
    check("abort_ferr", 64'(bus.frame_err_o), 64'd0);
    send_byte(8'hD4, 1'b1, 0);
    #(BIT_NS * 2);
    check("abort_count", 64'(bus.word_count_o), 64'd3);

    // Framing error then a clean word.
    send_byte(8'h55, 1'b0, 0);
    #(BIT_NS * 2);
    check("ferr_set", 64'(bus.frame_err_o), 64'd1);
    push_wr(3, 32'h4433_2211);
    send_word(32'h4433_2211, 0);
    #(BIT_NS * 2);
    check("ferr_sticky", 64'(bus.frame_err_o), 64'd1);
    check("ferr_count", 64'(bus.word_count_o), 64'd4);

    // Asynchronous reset in the middle of a frame.
    bus.rx_i = 1'b0;
    #(BIT_NS * 4 + 37);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.ready_o), 64'd0);
    check("mid_rst_addr", 64'(bus.mem_addr_o), 64'd0);
    check("mid_rst_wdata", 64'(bus.mem_wdata_o), 64'd0);
    check("mid_rst_count", 64'(bus.word_count_o), 64'd0);
    check("mid_rst_ferr", 64'(bus.frame_err_o), 64'd0);
    bus.rx_i = 1'b1;
    #(CLK_NS * 5);
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("mid_rst_ready_back", 64'(bus.ready_o), 64'd1);

    // Full back-to-back load.
    for (int i = 0; i < NUM_WORDS; i++) begin
      push_wr(i, 32'hA500_0000 + 32'(i));
    end
    for (int i = 0; i < NUM_WORDS; i++) begin
      send_word(32'hA500_0000 + 32'(i), 0);
    end
    #(BIT_NS * 2);
    check("full_done", 64'(bus.done_o), 64'd1);
    check("full_ready", 64'(bus.ready_o), 64'd0);

    send_word(32'hDEAD_BEEF, 0);
    #(BIT_NS * 2);
    check("post_done_count", 64'(bus.word_count_o), 64'(NUM_WORDS));
    check("post_done_sticky", 64'(bus.done_o), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Synthesizable UART receiver and word assembler that boots the core's instruction memory over a serial line. It receives 8N1 bytes LSB-first and packs each group of four bytes little-endian into a 32-bit word. Each completed word is written to sequential instruction-memory word addresses. It sits between the user-project UART pin and the ICCM write port, and it signals readiness to the external programmer and completion to the core reset/boot logic.

Parameters:
CLKS_PER_BIT, 87, clk_i cycles per UART bit (10 MHz / 115200 baud); must be ≥ 8.
NUM_WORDS, 65, words loaded before done_o asserts.
ADDR_W, 14, word-address width of mem_addr_o (16384 words).

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  loader enable; 0 holds FSM in IDLE and ignores rx_i
rx_i  input  1  UART serial input, idle high, asynchronous to clk_i
ready_o  output  1  loader waiting for data (en_i=1, not done)
mem_we_o  output  1  one-cycle instruction-memory write strobe
mem_addr_o  output  ADDR_W  word address of current write
mem_wdata_o  output  32  assembled word
word_count_o  output  ADDR_W+1  words written so far
done_o  output  1  NUM_WORDS words written; sticky until reset
frame_err_o  output  1  sticky framing-error flag

Behaviour:
- Reset (rst_ni=0, async): all outputs 0. FSM in IDLE. Byte index 0, word count 0, synchronizer flops preset to 1.
- rx_i passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
- ready_o = en_i & ~done_o, registered (one-cycle lag).
- Receive FSM, states IDLE, START, DATA, STOP:
  - IDLE: on rx_s=0 with en_i=1 and done_o=0 → START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 0 → DATA. If 1 (glitch) → IDLE, no error.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples. Shift into byte register LSB-first. → STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1 → byte accepted, → IDLE immediately, so a following start bit is caught with no gap. If 0 → set frame_err_o, discard byte, do not advance byte index, → IDLE.
- Tolerance: the sender may stretch the start bit by up to 15% of a bit period; mid-bit sampling must still decode correctly. Back-to-back frames with zero idle time must be received.
- Word assembly:
  - Accepted byte k (k=0..3) goes into wdata bits [8k+7:8k]. Byte index increments mod 4.
  - When byte 3 is accepted, mem_we_o pulses high for exactly one cycle, 1 cycle after the STOP sample.
  - During that pulse, mem_wdata_o holds the full word and mem_addr_o holds the current word count.
  - word_count_o increments in the cycle after the pulse. mem_addr_o and mem_wdata_o hold their values between writes.
- When word_count_o reaches NUM_WORDS, done_o sets in the same cycle as the increment and ready_o drops the next cycle. Afterwards the FSM stays in IDLE, ignores rx_i, and no further writes occur.
- en_i dropping mid-frame aborts the frame: FSM → IDLE, partial byte discarded. Byte index and word count are kept, and no error is flagged.
- Async reset mid-frame clears everything immediately; the next start edge begins a new word at address 0.
- frame_err_o clears only on reset.

Test Plan:
- Reset: rst_ni low mid-frame → all outputs 0 within the same cycle. After release with en_i=1, ready_o=1 two cycles later.
- Single word: send bytes 0x13,0x05,0x10,0x00 at 8681 ns/bit on a 10 MHz clock, each start bit stretched by 1000 ns → one mem_we_o pulse with addr 0, wdata 0x00100513; word_count_o=1.
- Full load: 65 words, word i = 0xA5000000+i, sent back-to-back with no idle → 65 pulses, addresses 0..64, correct data. done_o=1 after the 65th write, ready_o=0 one cycle later. An extra 4 bytes afterwards → no mem_we_o.
- Framing error: byte 0x55 with stop bit forced 0, then 0x11,0x22,0x33,0x44 → frame_err_o=1. The write carries wdata 0x44332211 at address 0.
- Glitch: rx_i low for 20 cycles (< CLKS_PER_BIT/2) → no byte accepted, no error, FSM returns to IDLE.
- Enable abort: drop en_i during the DATA bits of byte 1 of word 2, raise it again, then resend → the partial byte is discarded. The word completes at address 2 only after 3 more good bytes.
